stream_deserializer_eof2: RTL and testbench
===========================================

Name: stream_deserializer_eof2

Overview:
- Packs a narrow valid/ready stream with a per-element EOF flag into wide words of Ratio elements, each with a per-slice EOF vector.
- A frame's final wide word closes early at the EOF element, so it can be partial.
- Inverse of the team's EOF-per-slice serializer. A word leaving this block and passing through that serializer reproduces the original narrow stream exactly.
- Sits on wavetrace capture/readback paths wherever a byte stream must be widened to a memory or FIFO word.

Parameters:
- DataBits, 8, width of one narrow element.
- Ratio, 2, number of elements per wide word; minimum 2.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  narrow beat valid.
- in_ready  output  1  narrow beat accepted when in_valid & in_ready.
- in_data  input  DataBits  narrow element.
- in_eof  input  1  element is the last of its frame.
- out_valid  output  1  wide word valid.
- out_ready  input  1  downstream accepts the wide word.
- out_data  output  Ratio*DataBits  packed word; slice 0 = first received element (little endian).
- out_eof  output  Ratio  per-slice EOF; at most one bit set.

Behaviour:
- Reset (rst_n low, async; any state, including mid-word):
  - Slice counter returns to slice 0.
  - Accumulated partial data is discarded.
  - out_valid=0, out_data=0, out_eof=0.
  - in_ready=1 once out_valid=0.
- State:
  - One-hot slice counter `count[Ratio-1:0]`, reset value 1.
  - Accumulator holding slices 0..Ratio-2.
  - Output register holding out_data, out_eof and out_valid.
- in_ready = ~out_valid | out_ready. It is purely registered-state/out_ready driven and never depends on in_valid or in_eof.
- Accepted beat at slice k, when `count[Ratio-1]` or in_eof (word completes):
  - Output register loads:
    - slices 0..k-1 from the accumulator;
    - slice k from in_data;
    - slices k+1..Ratio-1 with zeros.
  - out_eof loads {in_eof at bit k, zeros elsewhere}.
  - out_valid <= 1.
  - count <= 1.
  - Accumulator contents after completion are don't-care; the next word overwrites them.
- Accepted beat at slice k, otherwise:
  - Accumulator slice k <= in_data.
  - count <= count << 1.
  - Output register is unchanged.
- Output transfer:
  - out_valid & out_ready with no new completing beat in the same cycle: out_valid <= 0.
  - A completing beat in the same cycle reloads the output register and out_valid stays 1. This gives back-to-back words, one narrow beat per cycle sustained.
- Latency: the wide word is visible one cycle after the completing narrow beat is accepted.
- A full word with no EOF presents out_eof=0.
- EOF on slice Ratio-1 gives out_eof = 1 << (Ratio-1).
- EOF on slice 0 gives a single-element word with out_eof=1.
- Backpressure:
  - While out_valid=1 and out_ready=0, in_ready=0. Accumulation also stalls; this is intentional for simplicity.
  - out_data and out_eof stay stable while out_valid=1 and out_ready=0.
- in_data and in_eof are ignored when in_valid=0. The counter advances only on an accepted beat.

Test Plan (DataBits=8, Ratio=4):
- Input 8'h11,22,33,44 (eof=0), then 55,66,77,88 (eof on 88), out_ready=1, one beat per cycle:
  - words are 32'h44332211 / eof 4'b0000, then 32'h88776655 / eof 4'b1000;
  - in_ready stays 1 throughout;
  - no gaps in either stream.
- Input 8'hA1, A2 (eof on A2), then B1 (eof):
  - word 32'h0000A2A1 with eof 4'b0010;
  - next word 32'h000000B1 with eof 4'b0001.
- Complete a word, then hold out_ready=0 for 5 cycles while in_valid=1:
  - in_ready=0 during the hold;
  - out_data and out_eof are stable;
  - after out_ready=1, the next word's beats are accepted and packed in order with no loss or duplication.
- Assert rst_n=0 asynchronously (mid-cycle) after 2 of 4 beats, release, then send C1..C4:
  - out_valid drops immediately on reset;
  - the output word is 32'hC4C3C2C1, with none of the pre-reset data.
- Random in_valid/out_ready toggling, 1000 frames of random length 1..20: a scoreboard comparing against a reference packer, plus a loopback through the EOF-per-slice serializer, shows a bit-exact stream and EOF positions.

Source files
------------

// File: rtl/stream_deserializer_eof2.sv
// Packs a narrow valid/ready stream with per-element EOF into Ratio-element wide words.
// A frame's last word closes early at the EOF element; unused upper slices are zero.
module stream_deserializer_eof2 #(
    parameter int unsigned DataBits = 8,
    parameter int unsigned Ratio    = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DataBits-1:0]         in_data,
    input  logic                        in_eof,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [Ratio*DataBits-1:0]   out_data,
    output logic [Ratio-1:0]            out_eof
);

    logic [Ratio-1:0]                 count_q, count_d;
    logic [Ratio-2:0][DataBits-1:0]   acc_q, acc_d;
    logic [Ratio-1:0][DataBits-1:0]   data_q, data_d;
    logic [Ratio-1:0]                 eof_q, eof_d;
    logic                             valid_q, valid_d;
    logic                             accept;
    logic                             seen;

    always_comb begin
        count_d  = count_q;
        acc_d    = acc_q;
        data_d   = data_q;
        eof_d    = eof_q;
        valid_d  = valid_q;
        seen     = 1'b0;
        in_ready = ~valid_q | out_ready;
        accept   = in_valid & in_ready;

        if (valid_q & out_ready) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            if (count_q[Ratio-1] | in_eof) begin
                // Slices below the current one come from the accumulator, above it are zeroed.
                for (int unsigned i = 0; i < Ratio - 1; i++) begin
                    if (count_q[i]) begin
                        data_d[i] = in_data;
                        seen      = 1'b1;
                    end else if (!seen) begin
                        data_d[i] = acc_q[i];
                    end else begin
                        data_d[i] = '0;
                    end
                end
                data_d[Ratio-1] = count_q[Ratio-1] ? in_data : '0;
                eof_d           = in_eof ? count_q : '0;
                valid_d         = 1'b1;
                count_d         = {{(Ratio-1){1'b0}}, 1'b1};
            end else begin
                for (int unsigned i = 0; i < Ratio - 1; i++) begin
                    if (count_q[i]) begin
                        acc_d[i] = in_data;
                    end
                end
                count_d = count_q << 1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {{(Ratio-1){1'b0}}, 1'b1};
            acc_q   <= '0;
            data_q  <= '0;
            eof_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            count_q <= count_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            eof_q   <= eof_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_eof   = eof_q;

endmodule

// File: tb/tb_stream_deserializer_eof2.sv
// Bench for stream_deserializer_eof2 (DataBits=8, Ratio=4): directed vector table, hand-written
// backpressure/reset sequences, and random frames checked against a grouping model plus serializer loopback.
module tb_stream_deserializer_eof2;

    localparam int unsigned DB = 8;
    localparam int unsigned R  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DB-1:0] in_data;
    logic          in_eof;
    logic          out_valid;
    logic          out_ready;
    logic [R*DB-1:0] out_data;
    logic [R-1:0]  out_eof;

    stream_deserializer_eof2 #(.DataBits(DB), .Ratio(R)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_eof    (in_eof),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_eof   (out_eof)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        e;
        logic        r;
        logic        exp_rdy;
        logic        exp_ov;
        logic [31:0] exp_od;
        logic [3:0]  exp_oe;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       e;
    } el_t;

    vec_t tbl[$];
    el_t  gen[$];
    el_t  sent[$];
    logic [7:0]  grp[$];
    logic [31:0] exp_d[$];
    logic [3:0]  exp_e[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic e, input logic r);
        in_valid  = v;
        in_data   = d;
        in_eof    = e;
        out_ready = r;
        #1;
    endtask

    initial begin
        logic        prev_hold;
        logic [31:0] prev_d;
        logic [3:0]  prev_e;
        logic        pend;
        logic        v;
        logic        r;
        logic [31:0] word;
        el_t         el;
        int          cycles;
        int          len;

        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        drive(1'b0, 8'h5A, 1'b1, 1'b0);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out_data", out_data, 32'd0);
        check("reset_out_eof", {28'd0, out_eof}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);

        tbl.push_back('{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0});
        tbl.push_back('{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0});
        tbl.push_back('{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0});
        tbl.push_back('{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 1'b1, 32'h44332211, 4'b0000});
        tbl.push_back('{1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0});
        tbl.push_back('{1'b1, 8'h66, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0});
        tbl.push_back('{1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0});
        tbl.push_back('{1'b1, 8'h88, 1'b1, 1'b1, 1'b1, 1'b1, 32'h88776655, 4'b1000});
        tbl.push_back('{1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0});
        tbl.push_back('{1'b1, 8'hA2, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000A2A1, 4'b0010});
        tbl.push_back('{1'b1, 8'hB1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h000000B1, 4'b0001});
        tbl.push_back('{1'b0, 8'hEE, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0});
        tbl.push_back('{1'b1, 8'hD1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0});
        tbl.push_back('{1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0});
        tbl.push_back('{1'b1, 8'hD2, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0});
        tbl.push_back('{1'b1, 8'hD3, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0});
        tbl.push_back('{1'b1, 8'hD4, 1'b1, 1'b1, 1'b1, 1'b1, 32'hD4D3D2D1, 4'b1000});

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].e, tbl[i].r);
            check($sformatf("tbl%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].exp_rdy});
            tick();
            check($sformatf("tbl%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].exp_ov});
            if (tbl[i].exp_ov) begin
                check($sformatf("tbl%0d_out_data", i), out_data, tbl[i].exp_od);
                check($sformatf("tbl%0d_out_eof", i), {28'd0, out_eof}, {28'd0, tbl[i].exp_oe});
            end
        end

        // Backpressure: word D held, upstream keeps offering E1.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'hE1, 1'b0, 1'b0);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("hold_out_data", out_data, 32'hD4D3D2D1);
            check("hold_out_eof", {28'd0, out_eof}, 32'h8);
            tick();
        end
        drive(1'b1, 8'hE1, 1'b0, 1'b1);
        check("release_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        drive(1'b1, 8'hE2, 1'b0, 1'b1);
        tick();
        drive(1'b1, 8'hE3, 1'b0, 1'b1);
        tick();
        drive(1'b1, 8'hE4, 1'b0, 1'b0);
        tick();
        check("post_hold_valid", {31'd0, out_valid}, 32'd1);
        check("post_hold_data", out_data, 32'hE4E3E2E1);
        check("post_hold_eof", {28'd0, out_eof}, 32'h0);

        // Asynchronous reset while a word is held.
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_out_data", out_data, 32'd0);
        check("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
        #3 rst_n = 1'b1;
        tick();

        // Asynchronous reset after two of four beats.
        drive(1'b1, 8'hF1, 1'b0, 1'b1);
        tick();
        drive(1'b1, 8'hF2, 1'b0, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
        tick();
        drive(1'b1, 8'hC1, 1'b0, 1'b1);
        tick();
        drive(1'b1, 8'hC2, 1'b0, 1'b1);
        tick();
        drive(1'b1, 8'hC3, 1'b0, 1'b1);
        tick();
        check("midword_rst_no_early_word", {31'd0, out_valid}, 32'd0);
        drive(1'b1, 8'hC4, 1'b0, 1'b1);
        tick();
        check("midword_rst_valid", {31'd0, out_valid}, 32'd1);
        check("midword_rst_data", out_data, 32'hC4C3C2C1);
        check("midword_rst_eof", {28'd0, out_eof}, 32'h0);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        tick();

        // Random frames against a grouping model and a serializer loopback.
        for (int f = 0; f < 1000; f++) begin
            len = $urandom_range(1, 20);
            for (int k = 0; k < len; k++) begin
                el.d = 8'($urandom);
                el.e = (k == len - 1);
                gen.push_back(el);
            end
        end

        prev_hold = 1'b0;
        prev_d    = '0;
        prev_e    = '0;
        pend      = 1'b0;
        cycles    = 0;
        while ((gen.size() > 0 || exp_d.size() > 0) && cycles < 90000) begin
            v = (gen.size() > 0) && ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            if (v) drive(1'b1, gen[0].d, gen[0].e, r);
            else   drive(1'b0, 8'($urandom), 1'($urandom), r);

            check("rnd_in_ready_rule", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
            if (pend) check("rnd_latency", {31'd0, out_valid}, 32'd1);
            if (prev_hold) begin
                check("rnd_hold_valid", {31'd0, out_valid}, 32'd1);
                check("rnd_hold_data", out_data, prev_d);
                check("rnd_hold_eof", {28'd0, out_eof}, {28'd0, prev_e});
            end

            if (out_valid && out_ready) begin
                if (exp_d.size() == 0) begin
                    check("rnd_spurious_word", 32'd1, 32'd0);
                end else begin
                    check("rnd_word_data", out_data, exp_d.pop_front());
                    check("rnd_word_eof", {28'd0, out_eof}, {28'd0, exp_e.pop_front()});
                end
                for (int i = 0; i < int'(R); i++) begin
                    if (sent.size() == 0) begin
                        check("loopback_underrun", 32'd1, 32'd0);
                        break;
                    end
                    el = sent.pop_front();
                    check("loopback_elem", {23'd0, out_eof[i], out_data[8*i +: 8]}, {23'd0, el.e, el.d});
                    if (out_eof[i]) break;
                end
            end

            prev_hold = out_valid && !out_ready;
            prev_d    = out_data;
            prev_e    = out_eof;
            pend      = 1'b0;

            if (in_valid && in_ready) begin
                el = gen.pop_front();
                sent.push_back(el);
                grp.push_back(el.d);
                if (el.e || grp.size() == R) begin
                    word = '0;
                    for (int i = 0; i < grp.size(); i++) word = word | (32'(grp[i]) << (8 * i));
                    exp_d.push_back(word);
                    exp_e.push_back(el.e ? 4'(1 << (grp.size() - 1)) : 4'd0);
                    grp.delete();
                    pend = 1'b1;
                end
            end
            tick();
            cycles++;
        end
        check("rnd_drain_in_budget", {31'd0, (cycles < 90000)}, 32'd1);
        check("loopback_leftover", sent.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
